// File: rtl/branch_control_unit.sv
// Branch control for the LEGv8 single-cycle PC: decodes B, CBZ and B.cond
// into UnCondBr/BrTaken, holds the NZCV flag register and branch statistics.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   instr_valid             1 = real instruction, 0 = bubble
//   instruction[31:0]       current fetched instruction
//   alu_negative/zero/
//   carry/overflow          live ALU flag results for this instruction
//   UnCondBr                1 = BrAddr26 path, 0 = CondAddr19 path
//   BrTaken                 1 = next PC is the branch target
//   CondAddr19, BrAddr26    raw address slices of the instruction
//   flags[3:0]              registered {N,Z,C,V}
//   taken_count             saturating count of taken branches
//   branch_count            saturating count of executed branches
module branch_control_unit #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid,
   input  logic [31:0]          instruction,
   input  logic                 alu_negative,
   input  logic                 alu_zero,
   input  logic                 alu_carry,
   input  logic                 alu_overflow,
   output logic                 UnCondBr,
   output logic                 BrTaken,
   output logic [18:0]          CondAddr19,
   output logic [25:0]          BrAddr26,
   output logic [3:0]           flags,
   output logic [CNT_WIDTH-1:0] taken_count,
   output logic [CNT_WIDTH-1:0] branch_count
);

   logic is_b;
   logic is_cbz;
   logic is_bcond;
   logic is_br;
   logic is_fset;
   logic live;
   logic cond_ok;
   logic fn, fz, fc, fv;

   assign CondAddr19 = instruction[23:5];
   assign BrAddr26   = instruction[25:0];

   assign is_b     = (instruction[31:26] == 6'b000101);
   assign is_cbz   = (instruction[31:24] == 8'b10110100);
   assign is_bcond = (instruction[31:24] == 8'b01010100);
   assign is_br    = is_b | is_cbz | is_bcond;

   assign is_fset = (instruction[31:21] == 11'h558)
                  | (instruction[31:21] == 11'h758)
                  | (instruction[31:21] == 11'h750)
                  | (instruction[31:22] == 10'h2C4)
                  | (instruction[31:22] == 10'h3C4);

   assign live = instr_valid & ~reset;

   assign {fn, fz, fc, fv} = flags;

   // B.cond reads only the registered flags; a flag write in the
   // same cycle becomes visible one cycle later.
   always_comb begin
      cond_ok = 1'b0;
      case (instruction[3:0])
         4'h0: cond_ok = fz;
         4'h1: cond_ok = ~fz;
         4'h2: cond_ok = fc;
         4'h3: cond_ok = ~fc;
         4'h4: cond_ok = fn;
         4'h5: cond_ok = ~fn;
         4'h6: cond_ok = fv;
         4'h7: cond_ok = ~fv;
         4'h8: cond_ok = fc & ~fz;
         4'h9: cond_ok = ~(fc & ~fz);
         4'hA: cond_ok = (fn == fv);
         4'hB: cond_ok = (fn != fv);
         4'hC: cond_ok = ~fz & (fn == fv);
         4'hD: cond_ok = ~(~fz & (fn == fv));
         default: cond_ok = 1'b1;
      endcase
   end

   always_comb begin
      UnCondBr = 1'b0;
      BrTaken  = 1'b0;
      if (live) begin
         unique case (1'b1)
            is_b: begin
               UnCondBr = 1'b1;
               BrTaken  = 1'b1;
            end
            is_cbz:   BrTaken = alu_zero;
            is_bcond: BrTaken = cond_ok;
            default: begin
               UnCondBr = 1'b0;
               BrTaken  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags        <= 4'b0000;
         taken_count  <= '0;
         branch_count <= '0;
      end else if (instr_valid) begin
         if (is_fset) begin
            flags <= {alu_negative, alu_zero,
                      alu_carry, alu_overflow};
         end
         if (is_br) begin
            if (branch_count != '1) begin
               branch_count <= branch_count + 1'b1;
            end
            if (BrTaken && (taken_count != '1)) begin
               taken_count <= taken_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_control_unit.sv
// Randomised scoreboard bench for branch_control_unit, checking a default
// width instance and a 4-bit counter instance against a reference model.
module tb_branch_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        alu_negative, alu_zero, alu_carry, alu_overflow;

   logic        ucb, bt;
   logic [18:0] c19;
   logic [25:0] b26;
   logic [3:0]  fl;
   logic [31:0] tc, bc;

   logic        ucb4, bt4;
   logic [18:0] c194;
   logic [25:0] b264;
   logic [3:0]  fl4;
   logic [3:0]  tc4, bc4;

   always #5 clk = ~clk;

   branch_control_unit dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid),
      .instruction(instruction),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .UnCondBr(ucb), .BrTaken(bt),
      .CondAddr19(c19), .BrAddr26(b26),
      .flags(fl), .taken_count(tc), .branch_count(bc)
   );

   branch_control_unit #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .instr_valid(instr_valid),
      .instruction(instruction),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .UnCondBr(ucb4), .BrTaken(bt4),
      .CondAddr19(c194), .BrAddr26(b264),
      .flags(fl4), .taken_count(tc4), .branch_count(bc4)
   );

   typedef struct {
      logic        st;
      logic        ucb;
      logic        bt;
      logic [18:0] c19;
      logic [25:0] b26;
      logic [3:0]  fl;
      logic [31:0] tc;
      logic [31:0] bc;
      logic [3:0]  tc4;
      logic [3:0]  bc4;
   } exp_t;

   exp_t q[$];

   int ncmp = 0;
   int nerr = 0;

   // reference model state
   logic        known = 1'b0;
   logic [3:0]  mfl;
   longint      mtc, mbc, mtc4, mbc4;

   function automatic logic cond_true(input logic [3:0] code,
                                      input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (code[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return 1'b1;
      endcase
      return code[0] ? !base : base;
   endfunction

   function automatic longint sat(input longint x, input longint mx);
      return (x >= mx) ? mx : x + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic v,
                       input logic [31:0] ins, input logic [3:0] nzcv);
      exp_t e;
      logic isb, iscbz, isbc, fset, lv;
      @(negedge clk);
      #1;
      reset        = r;
      instr_valid  = v;
      instruction  = ins;
      {alu_negative, alu_zero, alu_carry, alu_overflow} = nzcv;

      isb   = (ins[31:26] == 6'b000101);
      iscbz = (ins[31:24] == 8'hB4);
      isbc  = (ins[31:24] == 8'h54);
      fset  = (ins[31:21] inside {11'h558, 11'h758, 11'h750})
           || (ins[31:22] inside {10'h2C4, 10'h3C4});
      lv    = v && !r;

      e.st  = known;
      e.ucb = lv && isb;
      e.bt  = lv && (isb || (iscbz && nzcv[2])
                     || (isbc && cond_true(ins[3:0], mfl)));
      e.c19 = ins[23:5];
      e.b26 = ins[25:0];
      e.fl  = mfl;
      e.tc  = 32'(mtc);
      e.bc  = 32'(mbc);
      e.tc4 = 4'(mtc4);
      e.bc4 = 4'(mbc4);
      q.push_back(e);

      if (r) begin
         known = 1'b1;
         mfl   = 4'b0;
         mtc   = 0;
         mbc   = 0;
         mtc4  = 0;
         mbc4  = 0;
      end else if (v) begin
         if (fset) mfl = nzcv;
         if (isb || iscbz || isbc) begin
            mbc  = sat(mbc, 64'hFFFF_FFFF);
            mbc4 = sat(mbc4, 15);
            if (e.bt) begin
               mtc  = sat(mtc, 64'hFFFF_FFFF);
               mtc4 = sat(mtc4, 15);
            end
         end
      end
   endtask

   // monitor: samples the DUT one time unit after the driver each cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("UnCondBr", 32'(ucb), 32'(e.ucb));
            chk("BrTaken", 32'(bt), 32'(e.bt));
            chk("CondAddr19", 32'(c19), 32'(e.c19));
            chk("BrAddr26", 32'(b26), 32'(e.b26));
            chk("BrTaken_w4", 32'(bt4), 32'(e.bt));
            if (e.st) begin
               chk("flags", 32'(fl), 32'(e.fl));
               chk("taken_count", tc, e.tc);
               chk("branch_count", bc, e.bc);
               chk("taken_count_w4", 32'(tc4), 32'(e.tc4));
               chk("branch_count_w4", 32'(bc4), 32'(e.bc4));
            end
         end
      end
   end

   localparam logic [31:0] SUBS  = 32'hEB020023;
   localparam logic [31:0] ADDS  = 32'hAB020023;
   localparam logic [31:0] NOP   = 32'h8B1F03FF;

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0, 1: return {6'b000101, r[25:0]};
         2:    return {8'hB4, r[23:0]};
         3, 4: return {8'h54, r[23:0]};
         5:    return {11'h558, r[20:0]};
         6:    return {11'h758, r[20:0]};
         7:    return {11'h750, r[20:0]};
         8:    return r[0] ? {10'h2C4, r[21:0]}
                           : {10'h3C4, r[21:0]};
         default: return r;
      endcase
   endfunction

   initial begin
      reset        = 1'b1;
      instr_valid  = 1'b0;
      instruction  = 32'h0;
      {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0;

      step(1, 0, NOP, 4'b0);
      step(1, 1, SUBS, 4'b1111);
      step(0, 1, 32'h14000003, 4'b0);
      step(0, 0, NOP, 4'b0);
      step(0, 1, 32'h17FFFFFF, 4'b0);
      step(0, 0, 32'h17FFFFFF, 4'b0);
      step(0, 1, 32'hB4000041, 4'b0100);
      step(0, 1, 32'hB4000041, 4'b0000);
      step(0, 1, SUBS, 4'b0110);
      step(0, 1, 32'h54000080, 4'b0);
      step(0, 1, 32'h54000081, 4'b0);
      step(0, 1, 32'h54000088, 4'b0);
      step(0, 1, ADDS, 4'b1000);
      step(0, 1, 32'h5400008B, 4'b0);
      step(0, 1, 32'h5400008A, 4'b0);
      step(0, 1, ADDS, 4'b0100);
      step(0, 1, 32'h54000080, 4'b0);
      step(0, 1, NOP, 4'b1111);
      step(0, 1, 32'h54000080, 4'b0);

      step(1, 1, NOP, 4'b0);
      for (int i = 0; i < 17; i++) step(0, 1, 32'h14000001, 4'b0);
      step(0, 1, SUBS, 4'b1011);
      step(1, 1, SUBS, 4'b1111);
      step(0, 1, NOP, 4'b0);
      step(0, 1, 32'h54000080, 4'b0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 7) != 0),
              rand_instr(), 4'($urandom));
      end

      @(negedge clk);
      #5;
      ncmp++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
